// File: rtl/screen_reader_engine.sv
// Frame reader: walks CHANNELS blocks of FRAME_WORDS capture words, streams them out and reports progress to PIOs.
// Optional trailing CRC-16-CCITT word is enabled by defining SCREEN_READER_CRC_EN.
module screen_reader_engine #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 20,
   parameter int CHANNELS    = 2,
   parameter int FRAME_WORDS = 800,
   parameter int CH_STRIDE   = 262144
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [2:0]        events_export,
   output logic [2:0]        response_export,
   output logic [6:0]        loading_percentage_export,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_req,
   input  logic              rd_valid,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] out_data,
   output logic [2:0]        out_ch,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int TOTAL  = CHANNELS * FRAME_WORDS;
   localparam int ACC_W  = $clog2(TOTAL) + 2;
   localparam int WORD_W = $clog2(FRAME_WORDS + 1);

   localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(CH_STRIDE);
   localparam logic [ACC_W-1:0]  TOTAL_A   = ACC_W'(TOTAL);
   localparam logic [ACC_W-1:0]  STEP_A    = ACC_W'(100);
   localparam logic [2:0]        LAST_CH   = 3'(CHANNELS - 1);
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(FRAME_WORDS - 1);

   localparam logic [2:0] RSP_IDLE    = 3'b000;
   localparam logic [2:0] RSP_BUSY    = 3'b001;
   localparam logic [2:0] RSP_DONE    = 3'b010;
   localparam logic [2:0] RSP_ABORTED = 3'b011;
   localparam logic [2:0] RSP_ERROR   = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_WAIT    = 3'd2,
      S_PUSH    = 3'd3,
      S_DRAIN   = 3'd4,
      S_DONE    = 3'd5,
      S_ABORTED = 3'd6
`ifdef SCREEN_READER_CRC_EN
      , S_CRC   = 3'd7
`endif
   } state_t;

   state_t             state_r;
   logic [2:0]         ev_q_r;
   logic [2:0]         edge_r;
   logic               primed_r;
   logic [2:0]         ch_r;
   logic [WORD_W-1:0]  word_r;
   logic [ADDR_W-1:0]  base_r;
   logic [ACC_W-1:0]   acc_r;
   logic [2:0]         next_ch_s;
   logic [WORD_W-1:0]  next_word_s;
   logic [ADDR_W-1:0]  next_base_s;
   logic [ADDR_W-1:0]  next_addr_s;
   logic [ACC_W-1:0]   acc_sum_s;
   logic               start_s;
   logic               abort_s;
   logic               ack_s;
   logic               frame_end_s;

`ifdef SCREEN_READER_CRC_EN
   logic [15:0]        crc_r;

   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [DATA_W-1:0] d);
      logic [15:0] c;
      c = crc;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction
`endif

   assign start_s     = edge_r[0];
   assign abort_s     = edge_r[1];
   assign ack_s       = edge_r[2];
   assign frame_end_s = (ch_r == LAST_CH) && (word_r == LAST_WORD);

   // Next word position and address, plus percent accumulator candidate.
   always_comb begin
      acc_sum_s = acc_r + STEP_A;
      if (word_r == LAST_WORD) begin
         next_word_s = {WORD_W{1'b0}};
         next_ch_s   = ch_r + 3'd1;
         next_base_s = base_r + STRIDE_A;
      end else begin
         next_word_s = word_r + WORD_W'(1);
         next_ch_s   = ch_r;
         next_base_s = base_r;
      end
      next_addr_s = next_base_s + ADDR_W'(next_word_s);
   end

   // Rising-edge detection; the first cycle after reset only primes ev_q_r so held levels never fire.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         ev_q_r   <= 3'b000;
         edge_r   <= 3'b000;
         primed_r <= 1'b0;
      end else begin
         ev_q_r   <= events_export;
         primed_r <= 1'b1;
         edge_r   <= primed_r ? (events_export & ~ev_q_r) : 3'b000;
      end
   end

   // Frame sequencer with registered stream, read-port and PIO outputs.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_r                   <= S_IDLE;
         response_export           <= RSP_IDLE;
         loading_percentage_export <= 7'd0;
         rd_addr                   <= {ADDR_W{1'b0}};
         rd_req                    <= 1'b0;
         out_data                  <= {DATA_W{1'b0}};
         out_ch                    <= 3'd0;
         out_last                  <= 1'b0;
         out_valid                 <= 1'b0;
         ch_r                      <= 3'd0;
         word_r                    <= {WORD_W{1'b0}};
         base_r                    <= {ADDR_W{1'b0}};
         acc_r                     <= {ACC_W{1'b0}};
`ifdef SCREEN_READER_CRC_EN
         crc_r                     <= 16'hFFFF;
`endif
      end else begin
         rd_req <= 1'b0;
         case (state_r)
            S_IDLE, S_DONE, S_ABORTED: begin
               if (start_s) begin
                  state_r                   <= S_REQ;
                  rd_req                    <= 1'b1;
                  rd_addr                   <= {ADDR_W{1'b0}};
                  ch_r                      <= 3'd0;
                  word_r                    <= {WORD_W{1'b0}};
                  base_r                    <= {ADDR_W{1'b0}};
                  acc_r                     <= {ACC_W{1'b0}};
                  loading_percentage_export <= 7'd0;
                  response_export           <= RSP_BUSY;
`ifdef SCREEN_READER_CRC_EN
                  crc_r                     <= 16'hFFFF;
`endif
               end else if (ack_s && (state_r != S_IDLE)) begin
                  state_r         <= S_IDLE;
                  response_export <= RSP_IDLE;
               end
            end
            S_REQ: begin
               if (abort_s) begin
                  state_r         <= S_ABORTED;
                  response_export <= RSP_ABORTED;
               end else begin
                  if (start_s) response_export <= RSP_ERROR;
                  state_r <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A result landing with the abort edge is already retired, so skip DRAIN.
               if (abort_s) begin
                  if (rd_valid) begin
                     state_r         <= S_ABORTED;
                     response_export <= RSP_ABORTED;
                  end else begin
                     state_r <= S_DRAIN;
                  end
               end else begin
                  if (start_s) response_export <= RSP_ERROR;
                  if (rd_valid) begin
                     state_r   <= S_PUSH;
                     out_data  <= rd_data;
                     out_ch    <= ch_r;
                     out_valid <= 1'b1;
`ifdef SCREEN_READER_CRC_EN
                     out_last  <= 1'b0;
`else
                     out_last  <= frame_end_s;
`endif
                  end
               end
            end
            S_PUSH: begin
               if (abort_s) begin
                  state_r         <= S_ABORTED;
                  response_export <= RSP_ABORTED;
                  out_valid       <= 1'b0;
                  out_last        <= 1'b0;
               end else begin
                  if (start_s) response_export <= RSP_ERROR;
                  if (out_ready) begin
                     word_r <= next_word_s;
                     ch_r   <= next_ch_s;
                     base_r <= next_base_s;
                     if (acc_sum_s >= TOTAL_A) begin
                        acc_r                     <= acc_sum_s - TOTAL_A;
                        loading_percentage_export <= loading_percentage_export + 7'd1;
                     end else begin
                        acc_r <= acc_sum_s;
                     end
`ifdef SCREEN_READER_CRC_EN
                     crc_r <= crc16_step(crc_r, out_data);
`endif
                     if (frame_end_s) begin
`ifdef SCREEN_READER_CRC_EN
                        state_r  <= S_CRC;
                        out_data <= crc16_step(crc_r, out_data);
                        out_ch   <= 3'd7;
                        out_last <= 1'b1;
`else
                        state_r         <= S_DONE;
                        response_export <= RSP_DONE;
                        out_valid       <= 1'b0;
                        out_last        <= 1'b0;
`endif
                     end else begin
                        state_r   <= S_REQ;
                        rd_req    <= 1'b1;
                        rd_addr   <= next_addr_s;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                     end
                  end
               end
            end
`ifdef SCREEN_READER_CRC_EN
            S_CRC: begin
               if (abort_s) begin
                  state_r         <= S_ABORTED;
                  response_export <= RSP_ABORTED;
                  out_valid       <= 1'b0;
                  out_last        <= 1'b0;
               end else begin
                  if (start_s) response_export <= RSP_ERROR;
                  if (out_ready) begin
                     state_r         <= S_DONE;
                     response_export <= RSP_DONE;
                     out_valid       <= 1'b0;
                     out_last        <= 1'b0;
                  end
               end
            end
`endif
            S_DRAIN: begin
               if (start_s) response_export <= RSP_ERROR;
               if (rd_valid) begin
                  state_r         <= S_ABORTED;
                  response_export <= RSP_ABORTED;
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_screen_reader_engine.sv
// Directed bench for screen_reader_engine: table of full frames plus hand sequences for abort, drain, reset and event races.
// Builds with or without SCREEN_READER_CRC_EN; with it, each frame ends with a checked CRC word.
module tb_screen_reader_engine;

   localparam int DW     = 16;
   localparam int AW     = 20;
   localparam int CH     = 2;
   localparam int FW     = 100;
   localparam int STRIDE = 262144;
   localparam int TOTAL  = CH * FW;
`ifdef SCREEN_READER_CRC_EN
   localparam int NSTREAM = TOTAL + 1;
`else
   localparam int NSTREAM = TOTAL;
`endif

   logic          clk = 1'b0;
   logic          reset_reset_n = 1'b0;
   logic [2:0]    events_export = 3'b000;
   logic [2:0]    response_export;
   logic [6:0]    loading_percentage_export;
   logic [AW-1:0] rd_addr;
   logic          rd_req;
   logic          rd_valid = 1'b0;
   logic [DW-1:0] rd_data = '0;
   logic [DW-1:0] out_data;
   logic [2:0]    out_ch;
   logic          out_last;
   logic          out_valid;
   logic          out_ready = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;
   int lat      = 1;
   int cnt      = 0;
   logic [AW-1:0] addr_q = '0;

   typedef struct {
      int         lat;
      int         rmode;
      int         err_at;
      int         chk_at;
      logic [2:0] exp_mid;
      int         exp_words;
      logic [2:0] exp_resp;
      int         exp_pct;
   } frame_vec_t;

   frame_vec_t vecs [4];

   screen_reader_engine #(
      .DATA_W(DW), .ADDR_W(AW), .CHANNELS(CH), .FRAME_WORDS(FW), .CH_STRIDE(STRIDE)
   ) dut (
      .clk_clk(clk),
      .reset_reset_n(reset_reset_n),
      .events_export(events_export),
      .response_export(response_export),
      .loading_percentage_export(loading_percentage_export),
      .rd_addr(rd_addr),
      .rd_req(rd_req),
      .rd_valid(rd_valid),
      .rd_data(rd_data),
      .out_data(out_data),
      .out_ch(out_ch),
      .out_last(out_last),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // Capture memory model: data = address[15:0], returned 'lat' cycles after the request cycle.
   always @(posedge clk) begin
      if (rd_req) begin
         addr_q <= rd_addr;
         if (lat == 1) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_addr[15:0];
         end else begin
            rd_valid <= 1'b0;
            cnt      <= lat - 1;
         end
      end else if (cnt == 1) begin
         rd_valid <= 1'b1;
         rd_data  <= addr_q[15:0];
         cnt      <= 0;
      end else begin
         rd_valid <= 1'b0;
         if (cnt > 0) cnt <= cnt - 1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] exp_addr(input int n);
      logic [31:0] a;
      a = (n / FW) * STRIDE + (n % FW);
      return a[AW-1:0];
   endfunction

   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [15:0] d);
      logic [15:0] c;
      c = crc;
      for (int i = 15; i >= 0; i--) begin
         if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   task automatic start_frame(input logic [2:0] ev);
      @(negedge clk);
      events_export = ev;
      @(negedge clk);
      check("start_early", rd_req, 1'b0);
      events_export = 3'b000;
      @(negedge clk);
      check("start_req", {rd_req, rd_addr, response_export, loading_percentage_export},
            {1'b1, 20'h00000, 3'b001, 7'd0});
   endtask

   task automatic ack_frame(input int exp_pct);
      @(negedge clk);
      events_export = 3'b100;
      @(negedge clk);
      events_export = 3'b000;
      @(negedge clk);
      check("ack", {response_export, loading_percentage_export}, {3'b000, 7'(exp_pct)});
   endtask

   task automatic run_frame(input frame_vec_t v, input int reset_at);
      int n;
      int extra;
      int hold;
      bit done;
      bit pend_pct;
      bit stall_prev;
      bit mid_done;
      bit err_done;
      logic [19:0] stall_word;
      logic [15:0] crc;
      logic [AW-1:0] ea;
      logic last_exp;
      n = 0; extra = 0; hold = 0; done = 1'b0; pend_pct = 1'b0; stall_prev = 1'b0;
      mid_done = 1'b0; err_done = 1'b0; stall_word = '0; crc = 16'hFFFF;
      lat = v.lat;
      out_ready = 1'b1;
      start_frame(3'b001);
      for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
         @(negedge clk);
         out_ready = (v.rmode != 0) ? (cyc % 3 == 2) : 1'b1;
         if (hold > 0) begin
            hold--;
            if (hold == 0) events_export = 3'b000;
         end
         if (pend_pct) begin
            check("pct_step", loading_percentage_export, (100 * n) / TOTAL);
            pend_pct = 1'b0;
         end
         if (stall_prev) check("stall_hold", {out_valid, out_data, out_ch, out_last}, {1'b1, stall_word});
         if (out_valid && out_ready) begin
            if (n < TOTAL) begin
               ea = exp_addr(n);
`ifdef SCREEN_READER_CRC_EN
               last_exp = 1'b0;
`else
               last_exp = (n == TOTAL - 1);
`endif
               check("word", {out_data, out_ch, out_last}, {ea[15:0], 3'(n / FW), last_exp});
               crc = crc_step(crc, ea[15:0]);
               n++;
               pend_pct = 1'b1;
            end else begin
               check("crc_word", {out_data, out_ch, out_last}, {crc, 3'd7, 1'b1});
               extra++;
            end
         end
         stall_prev = out_valid && !out_ready;
         stall_word = {out_data, out_ch, out_last};
         if (!mid_done && n == v.chk_at) begin
            check("mid_resp", response_export, v.exp_mid);
            mid_done = 1'b1;
         end
         if (n == reset_at) begin
            reset_reset_n = 1'b0;
            #1;
            check("reset_zero", {response_export, loading_percentage_export, rd_addr, rd_req,
                                 out_data, out_ch, out_last, out_valid}, 64'h0);
            done = 1'b1;
         end else if (!err_done && n == v.err_at) begin
            events_export = 3'b001;
            hold = 2;
            err_done = 1'b1;
         end
         if (response_export == 3'b010) done = 1'b1;
      end
      if (reset_at < 0) begin
         check("frame_end", done, 1'b1);
         check("frame_words", n + extra, v.exp_words);
         check("frame_resp", {response_export, loading_percentage_export},
               {v.exp_resp, 7'(v.exp_pct)});
      end
   endtask

   initial begin
      bit seen;
      bit any_valid;
      vecs[0] = '{1, 0, -1,  60, 3'b001, NSTREAM, 3'b010, 100};
      vecs[1] = '{1, 1, -1,  60, 3'b001, NSTREAM, 3'b010, 100};
      vecs[2] = '{3, 0, 50,  60, 3'b100, NSTREAM, 3'b010, 100};
      vecs[3] = '{2, 1, 10, 150, 3'b100, NSTREAM, 3'b010, 100};

      // Reset with start held high: outputs zero, and no start after release.
      events_export = 3'b001;
      repeat (3) @(negedge clk);
      check("reset_outputs", {response_export, loading_percentage_export, rd_addr, rd_req,
                              out_data, out_ch, out_last, out_valid}, 64'h0);
      reset_reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("held_start", {rd_req, response_export}, {1'b0, 3'b000});
      end
      events_export = 3'b000;

      // Abort in IDLE is ignored.
      @(negedge clk);
      events_export = 3'b010;
      repeat (2) @(negedge clk);
      events_export = 3'b000;
      @(negedge clk);
      check("idle_abort", {rd_req, response_export}, {1'b0, 3'b000});

      for (int i = 0; i < 4; i++) begin
         run_frame(vecs[i], -1);
         ack_frame(vecs[i].exp_pct);
      end

      // Abort while a slow read is outstanding: DRAIN swallows the late result.
      lat = 5;
      out_ready = 1'b1;
      start_frame(3'b001);
      events_export = 3'b010;
      @(negedge clk);
      events_export = 3'b000;
      @(negedge clk);
      check("drain_busy0", response_export, 3'b001);
      @(negedge clk);
      check("drain_busy1", response_export, 3'b001);
      any_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) any_valid = 1'b1;
      end
      check("drain_no_valid", any_valid, 1'b0);
      check("drain_aborted", {response_export, loading_percentage_export}, {3'b011, 7'd0});
      ack_frame(0);

      // Abort while a word is stalled in PUSH, then start+ack restart and abort+start race.
      lat = 1;
      out_ready = 1'b0;
      start_frame(3'b001);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      check("push_valid", {seen, out_data, out_ch}, {1'b1, 16'h0000, 3'd0});
      events_export = 3'b010;
      @(negedge clk);
      events_export = 3'b000;
      check("push_abort_pre", {out_valid, response_export}, {1'b1, 3'b001});
      @(negedge clk);
      check("push_abort", {out_valid, response_export}, {1'b0, 3'b011});
      start_frame(3'b101);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      check("race_valid", seen, 1'b1);
      events_export = 3'b011;
      @(negedge clk);
      events_export = 3'b000;
      @(negedge clk);
      check("abort_beats_start", {out_valid, response_export}, {1'b0, 3'b011});
      ack_frame(0);
      out_ready = 1'b1;

      // Reset in mid-frame, then a fresh frame starts from address 0.
      run_frame(vecs[0], 57);
      repeat (2) @(negedge clk);
      reset_reset_n = 1'b1;
      run_frame(vecs[0], -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
